uart8_receiver: RTL and testbench

8-bit UART receiver. The direct downstream partner of the 8-bit transmitter: it consumes the serial tx line and recovers bytes framed as 1 start bit, 8 data bits LSB-first and 1 stop bit. It runs on an oversampled clock (OVERSAMPLE x baud). It presents each byte with a one-cycle done pulse, and reports framing errors with a one-cycle err pulse.

---
 rtl/uart8_receiver_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart8_receiver.sv | 136 +++++++++++++
 tb/tb_uart8_receiver.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart8_receiver_pkg.sv
// Shared UART definitions: frame state encoding, data width and default oversampling.
// The transmitter uses the same state encoding.
package uart8_receiver_pkg;

    localparam int unsigned DataWidth         = 8;
    localparam int unsigned DefaultOversample = 16;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StStartBit  = 3'd1,
        StDataBits  = 3'd2,
        StStopBit   = 3'd3,
        StParityBit = 3'd4
    } uart_state_e;

    // Even-parity bit that makes the total number of ones (data + parity) even.
    function automatic logic even_parity(input logic [DataWidth-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous rx line plus falling-edge detector.
// All flops reset to 1, which is the idle line level.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            rx_q   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
            rx_q   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = rx_q & ~rx_s;

endmodule

// File: rtl/uart8_receiver.sv
// 8N1 UART receiver with midpoint sampling on an OVERSAMPLE x baud clock.
// Define UART_RX_PARITY_EN to expect an even-parity bit between bit 7 and the stop bit.
module uart8_receiver
    import uart8_receiver_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = DefaultOversample,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in,
    output logic [DataWidth-1:0] out,
    output logic                 done,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam logic [CntW-1:0] HalfLast = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(OVERSAMPLE - 1);

    uart_state_e          state_q;
    logic [CntW-1:0]      cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DataWidth-1:0] shift_q;
    logic                 rx_s;
    logic                 fall;
    logic                 stop_ok;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .rx_s  (rx_s),
        .fall  (fall)
    );

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;
    assign stop_ok = rx_s & ~parity_err_q;
`else
    assign stop_ok = rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            out          <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_q)
                StIdle: begin
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
                    parity_err_q <= 1'b0;
`endif
                    // A line that is already low never shows a falling edge, so a break
                    // or the tail of a bad stop bit cannot start a frame.
                    if (en && fall) begin
                        state_q <= StStartBit;
                        busy    <= 1'b1;
                    end
                end
                StStartBit: begin
                    if (cnt_q == HalfLast) begin
                        cnt_q   <= '0;
                        state_q <= rx_s ? StIdle : StDataBits;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDataBits: begin
                    if (cnt_q == BitLast) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s, shift_q[DataWidth-1:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= StParityBit;
`else
                            state_q <= StStopBit;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParityBit: begin
                    if (cnt_q == BitLast) begin
                        cnt_q        <= '0;
                        parity_err_q <= (even_parity(shift_q) != rx_s);
                        state_q      <= StStopBit;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                StStopBit: begin
                    if (cnt_q == BitLast) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        if (stop_ok) begin
                            out  <= shift_q;
                            done <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart8_receiver.sv
// Self-checking bench for uart8_receiver: directed scenarios plus randomized frames
// scored against a frame-level model of expected done/err events and their timing.
module tb_uart8_receiver;

    localparam int unsigned OS   = 16;
    localparam int unsigned SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NBITS = 10;
`else
    localparam int unsigned NBITS = 9;
`endif
    // Line edge -> synchronizer -> edge register -> half bit -> remaining bit periods.
    localparam int unsigned LAT = SYNC + 1 + OS / 2 + NBITS * OS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       in = 1'b1;
    logic [7:0] out;
    logic       done;
    logic       busy;
    logic       err;

    uart8_receiver #(
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .in    (in),
        .out   (out),
        .done  (done),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        bit          is_err;
        logic [7:0]  data;
    } ev_t;

    ev_t         obs_q[$];
    ev_t         exp_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          busy_cnt = 0;
    bit          prev_pulse = 1'b0;
    logic [7:0]  last_good = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (done || err) begin
                check("done_err_exclusive", {31'd0, done & err}, 32'd0);
                check("pulse_not_repeated", {31'd0, prev_pulse}, 32'd0);
                e.cyc    = cyc;
                e.is_err = err;
                e.data   = out;
                obs_q.push_back(e);
            end
            prev_pulse = done | err;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic line_bit(input logic b, input logic exp_busy, input string tag);
        in = b;
        repeat (OS / 2) @(negedge clk);
        check(tag, {31'd0, busy}, {31'd0, exp_busy});
        repeat (OS - OS / 2) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) line_bit(1'b1, 1'b0, "idle_busy");
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_flip,
                              input bit accept);
        int unsigned t0;
        ev_t         e;
        bit          bad;
        t0 = cyc;
        line_bit(1'b0, accept, "start_busy");
        for (int i = 0; i < 8; i++) line_bit(d[i], accept, "data_busy");
`ifdef UART_RX_PARITY_EN
        line_bit((^d) ^ par_flip, accept, "parity_busy");
        bad = !stop || par_flip;
`else
        bad = !stop;
`endif
        line_bit(stop, accept, "stop_busy");
        if (accept) begin
            e.cyc    = t0 + LAT;
            e.is_err = bad;
            e.data   = bad ? last_good : d;
            exp_q.push_back(e);
            if (!bad) last_good = d;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        #1;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
            check({tag, "_kind"}, {31'd0, obs_q[i].is_err}, {31'd0, exp_q[i].is_err});
            check({tag, "_data"}, {24'd0, obs_q[i].data}, {24'd0, exp_q[i].data});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        bit         stop;
        bit         pf;
        int         gap;

        repeat (3) @(negedge clk);
        check("reset_out", {24'd0, out}, 32'h00);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        idle_bits(1);
        en = 1'b1;

        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        idle_bits(1);
        drain("frame_a5");
        check("out_a5", {24'd0, out}, 32'hA5);

        send_frame(8'h00, 1'b1, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        idle_bits(1);
        drain("back_to_back");

        busy_cnt = 0;
        in = 1'b0;
        repeat (4) @(negedge clk);
        in = 1'b1;
        repeat (2 * OS) @(negedge clk);
        check("glitch_busy_len", {31'd0, (busy_cnt >= OS / 2 && busy_cnt <= OS / 2 + 2)}, 32'd1);
        drain("glitch");
        check("glitch_out", {24'd0, out}, 32'hFF);

        send_frame(8'h11, 1'b1, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) line_bit(1'b0, 1'b0, "break_busy");
        idle_bits(1);
        drain("framing_err");
        check("err_out_held", {24'd0, out}, 32'h11);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
        idle_bits(1);
        drain("after_err");

        en = 1'b0;
        send_frame(8'h77, 1'b1, 1'b0, 1'b0);
        idle_bits(1);
        en = 1'b1;
        fork
            send_frame(8'h42, 1'b1, 1'b0, 1'b1);
            begin
                repeat (3 * OS) @(negedge clk);
                en = 1'b0;
            end
        join
        en = 1'b1;
        idle_bits(1);
        drain("enable");
        check("en_out", {24'd0, out}, 32'h42);

        d = 8'h99;
        in = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            in = d[i];
            repeat (OS) @(negedge clk);
        end
        in = d[4];
        repeat (OS / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_out", {24'd0, out}, 32'h00);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_err", {31'd0, err}, 32'd0);
        last_good = 8'h00;
        in = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(2);
        drain("midreset");
        send_frame(8'h66, 1'b1, 1'b0, 1'b1);
        idle_bits(1);
        drain("after_reset");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        idle_bits(1);
        drain("parity_err");
        check("parity_out_held", {24'd0, out}, 32'h66);
`endif

        for (int k = 0; k < 24; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(7) != 0);
`ifdef UART_RX_PARITY_EN
            pf   = ($urandom_range(7) == 0);
`else
            pf   = 1'b0;
`endif
            gap  = stop ? int'($urandom_range(2)) : 1 + int'($urandom_range(1));
            send_frame(d, stop, pf, 1'b1);
            idle_bits(gap);
        end
        idle_bits(1);
        drain("random");
        check("random_last_out", {24'd0, out}, {24'd0, last_good});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
